alu_sweep_driver: RTL and testbench

Stimulus-and-capture engine for the registered ALU timing harness; it is the initiator side of the harness's A/B/sel → Out/flags interface. On start it sweeps every opcode and every operand pair, holds each vector stable for the harness latency, and samples the result and flags. Each result is folded into a 16-bit MISR signature, so the board or bench compares a single word against a golden value.

---
 rtl/alu_sweep_driver.sv | 184 ++++++++++++++++++
 tb/tb_alu_sweep_driver.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_driver.sv
// ---------------------------------------------------------------------------
// alu_sweep_driver
//
// Stimulus-and-capture engine for the registered ALU timing harness. On start
// it walks every opcode (outer loop), every A operand (middle loop) and every
// B operand (inner loop). Each vector is held for LAT+2 cycles. The harness
// result and flags are then sampled and folded into a 16-bit MISR, so the
// whole sweep reduces to a single signature word.
//
// Parameters:
//   N     operand/result width, 1..12
//   NOPS  number of opcodes swept (sel = 0..NOPS-1), 1..16
//   LAT   extra wait cycles between issue and capture, 0..15
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-low reset
//   start        level request, sampled only while idle
//   a_out/b_out  operands to the harness (N bits)
//   sel_out      opcode to the harness (4 bits)
//   res_in       harness result (N bits)
//   z_in, o_in, ca_in, neg_in   harness flags
//   busy         high while a vector is being issued, waited on or captured
//   done         one-cycle pulse when the sweep completes
//   sig          MISR signature (16 bits)
//   vec_cnt      vectors captured since the last start (2N+4 bits)
//
// Optional feature (macro ALU_DRV_CYCLE_CNT_EN):
//   adds cyc_cnt (32 bits). It counts the busy cycles of the current sweep,
//   saturates at all-ones and is cleared by reset and by start.
// ---------------------------------------------------------------------------
module alu_sweep_driver #(
  parameter int N    = 5,
  parameter int NOPS = 10,
  parameter int LAT  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [N-1:0]   a_out,
  output logic [N-1:0]   b_out,
  output logic [3:0]     sel_out,
  input  logic [N-1:0]   res_in,
  input  logic           z_in,
  input  logic           o_in,
  input  logic           ca_in,
  input  logic           neg_in,
  output logic           busy,
  output logic           done,
  output logic [15:0]    sig,
  output logic [2*N+3:0] vec_cnt
`ifdef ALU_DRV_CYCLE_CNT_EN
  ,
  output logic [31:0]    cyc_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [N-1:0] OPD_MAX  = '1;
  localparam logic [3:0]   SEL_MAX  = 4'(NOPS - 1);
  localparam bit           HAS_WAIT = (LAT > 0);
  // Wait counter preload; WAIT leaves when it reaches zero, giving LAT cycles.
  localparam logic [3:0]   WAIT_LOAD = HAS_WAIT ? 4'(LAT - 1) : 4'd0;

  logic [2:0]   state_q;
  logic [2:0]   state_d;
  logic [3:0]   wait_q;
  logic         last_vec;
  logic [N-1:0] a_nxt;
  logic [N-1:0] b_nxt;
  logic [3:0]   sel_nxt;
  logic [15:0]  fold_in;
  logic         misr_fb;

  assign last_vec = (a_out == OPD_MAX) && (b_out == OPD_MAX) && (sel_out == SEL_MAX);
  assign misr_fb  = sig[15] ^ sig[13] ^ sig[12] ^ sig[10];

  // Captured word {neg, ca, o, z, res}, zero-extended to the MISR width.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    fold_in        = '0;
    fold_in[N+3:0] = {neg_in, ca_in, o_in, z_in, res_in};
  end

  // Next vector: b is the fastest digit, then a, then sel; each wraps at
  // its own maximum and carries into the next.
  always_comb begin
    a_nxt   = a_out;
    b_nxt   = b_out;
    sel_nxt = sel_out;
    if (b_out == OPD_MAX) begin
      b_nxt = '0;
      if (a_out == OPD_MAX) begin
        a_nxt   = '0;
        sel_nxt = (sel_out == SEL_MAX) ? 4'd0 : sel_out + 4'd1;
      end else begin
        a_nxt = a_out + 1'b1;
      end
    end else begin
      b_nxt = b_out + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ISSUE;
      S_ISSUE:   state_d = HAS_WAIT ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_q == 4'd0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_vec ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // busy and done are decoded from the next state and registered, so they
  // line up with the state they describe without a combinational output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      a_out   <= '0;
      b_out   <= '0;
      sel_out <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sig     <= 16'd0;
      vec_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      busy    <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
      done    <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sig     <= 16'd0;
            vec_cnt <= '0;
            a_out   <= '0;
            b_out   <= '0;
            sel_out <= 4'd0;
          end
        end
        S_ISSUE: begin
          wait_q <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
        end
        S_CAPTURE: begin
          sig     <= {sig[14:0], misr_fb} ^ fold_in;
          vec_cnt <= vec_cnt + 1'b1;
          // The final vector stays on the outputs after the sweep ends.
          if (!last_vec) begin
            a_out   <= a_nxt;
            b_out   <= b_nxt;
            sel_out <= sel_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_DRV_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= 32'd0;
    end else if ((state_q == S_IDLE) && start) begin
      cyc_cnt <= 32'd0;
    end else if (busy && (cyc_cnt != 32'hFFFF_FFFF)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sweep_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_sweep_driver
//
// Four driver instances with different parameter sets share one clock:
//   u0  N=2 NOPS=1  LAT=1  sweep length, busy/done timing, mid-sweep reset,
//                          optional cycle counter
//   u1  N=2 NOPS=2  LAT=0  vector ordering and signature against a
//                          time-indexed model of the sweep
//   u2  N=1 NOPS=1  LAT=1  signature folds with a constant result of 1
//   u3  N=5 NOPS=10 LAT=1  full sweep through a behavioural registered ALU,
//                          signature against the bench's own MISR over all ops
// ---------------------------------------------------------------------------
module tb_alu_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MISR step written straight from the signature rule.
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] v);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ v;
  endfunction

  // Behavioural 5-bit ALU: returns {neg, ca, o, z, res}.
  function automatic logic [8:0] alu5(input int sel, input logic [4:0] a, input logic [4:0] b);
    logic [5:0] w;
    logic [4:0] r;
    logic       c;
    logic       o;
    w = '0; r = '0; c = 1'b0; o = 1'b0;
    case (sel)
      0: begin w = {1'b0, a} + {1'b0, b}; r = w[4:0]; c = w[5]; o = (a[4] == b[4]) && (r[4] != a[4]); end
      1: begin w = {1'b0, a} - {1'b0, b}; r = w[4:0]; c = w[5]; o = (a[4] != b[4]) && (r[4] != a[4]); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = {a[3:0], 1'b0}; c = a[4]; end
      7: begin r = {1'b0, a[4:1]}; c = a[0]; end
      8: begin w = {1'b0, a} + 6'd1; r = w[4:0]; c = w[5]; o = (a == 5'b01111); end
      9: r = b;
      default: r = '0;
    endcase
    return {r[4], c, o, (r == 5'd0), r};
  endfunction

  // Response the u1 stand-in harness gives: res=a^b, z, o=sel[0], ca=0, neg=res[1].
  function automatic logic [15:0] resp1(input int sel, input int a, input int b);
    logic [1:0] r;
    logic       s0;
    r  = 2'(a ^ b);
    s0 = 1'(sel);
    return 16'({r[1], 1'b0, s0, (r == 2'd0), r});
  endfunction

  // ---------------- u0 : N=2 NOPS=1 LAT=1 ----------------
  logic        rst0, start0;
  logic [1:0]  a0, b0;
  logic [3:0]  sel0;
  logic        busy0, done0;
  logic [15:0] sig0;
  logic [7:0]  vc0;
`ifdef ALU_DRV_CYCLE_CNT_EN
  logic [31:0] cc0, cc1, cc2, cc3;
`endif

  alu_sweep_driver #(.N(2), .NOPS(1), .LAT(1)) u0 (
    .clk(clk), .rst(rst0), .start(start0),
    .a_out(a0), .b_out(b0), .sel_out(sel0),
    .res_in(2'b00), .z_in(1'b0), .o_in(1'b0), .ca_in(1'b0), .neg_in(1'b0),
    .busy(busy0), .done(done0), .sig(sig0), .vec_cnt(vc0)
`ifdef ALU_DRV_CYCLE_CNT_EN
    , .cyc_cnt(cc0)
`endif
  );

  // ---------------- u1 : N=2 NOPS=2 LAT=0 ----------------
  logic        rst1, start1;
  logic [1:0]  a1, b1, res1;
  logic [3:0]  sel1;
  logic        z1, o1, neg1;
  logic        busy1, done1;
  logic [15:0] sig1;
  logic [7:0]  vc1;

  assign res1 = a1 ^ b1;
  assign z1   = (res1 == 2'b00);
  assign o1   = sel1[0];
  assign neg1 = res1[1];

  alu_sweep_driver #(.N(2), .NOPS(2), .LAT(0)) u1 (
    .clk(clk), .rst(rst1), .start(start1),
    .a_out(a1), .b_out(b1), .sel_out(sel1),
    .res_in(res1), .z_in(z1), .o_in(o1), .ca_in(1'b0), .neg_in(neg1),
    .busy(busy1), .done(done1), .sig(sig1), .vec_cnt(vc1)
`ifdef ALU_DRV_CYCLE_CNT_EN
    , .cyc_cnt(cc1)
`endif
  );

  // ---------------- u2 : N=1 NOPS=1 LAT=1 ----------------
  logic        rst2, start2;
  logic        a2, b2;
  logic [3:0]  sel2;
  logic        busy2, done2;
  logic [15:0] sig2;
  logic [5:0]  vc2;

  alu_sweep_driver #(.N(1), .NOPS(1), .LAT(1)) u2 (
    .clk(clk), .rst(rst2), .start(start2),
    .a_out(a2), .b_out(b2), .sel_out(sel2),
    .res_in(1'b1), .z_in(1'b0), .o_in(1'b0), .ca_in(1'b0), .neg_in(1'b0),
    .busy(busy2), .done(done2), .sig(sig2), .vec_cnt(vc2)
`ifdef ALU_DRV_CYCLE_CNT_EN
    , .cyc_cnt(cc2)
`endif
  );

  // ---------------- u3 : N=5 NOPS=10 LAT=1, registered ALU harness ----------------
  logic        rst3, start3;
  logic [4:0]  a3, b3;
  logic [3:0]  sel3;
  logic        busy3, done3;
  logic [15:0] sig3;
  logic [13:0] vc3;
  logic [4:0]  ha, hb;
  logic [3:0]  hs;
  logic [8:0]  hout;

  // Harness: operand registers on posedge, result register on negedge.
  always @(posedge clk) begin
    ha <= a3;
    hb <= b3;
    hs <= sel3;
  end
  always @(negedge clk) hout <= alu5(int'(hs), ha, hb);

  alu_sweep_driver #(.N(5), .NOPS(10), .LAT(1)) u3 (
    .clk(clk), .rst(rst3), .start(start3),
    .a_out(a3), .b_out(b3), .sel_out(sel3),
    .res_in(hout[4:0]), .z_in(hout[5]), .o_in(hout[6]), .ca_in(hout[7]), .neg_in(hout[8]),
    .busy(busy3), .done(done3), .sig(sig3), .vec_cnt(vc3)
`ifdef ALU_DRV_CYCLE_CNT_EN
    , .cyc_cnt(cc3)
`endif
  );

  // ---------------- stimulus and checking ----------------
  initial begin
    int first_done, busy_cnt, done_cnt, k, idx;
    logic [15:0] m_sig;
    logic [9:0]  cap_log[$];

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;

    // Pin the bench's own reference functions.
    check("pin misr(0,1)", misr(16'h0000, 16'h0001), 64'h0001);
    check("pin misr(1,1)", misr(16'h0001, 16'h0001), 64'h0003);
    check("pin misr feedback", misr(16'h8000, 16'h0000), 64'h0001);
    check("pin alu add 31+1", alu5(0, 5'd31, 5'd1), 64'h0A0);
    check("pin alu sub 0-1", alu5(1, 5'd0, 5'd1), 64'h19F);

    repeat (3) @(negedge clk);
    check("u0 reset a", a0, 0);
    check("u0 reset b", b0, 0);
    check("u0 reset sel", sel0, 0);
    check("u0 reset busy", busy0, 0);
    check("u0 reset done", done0, 0);
    check("u0 reset sig", sig0, 0);
    check("u0 reset vec_cnt", vc0, 0);
`ifdef ALU_DRV_CYCLE_CNT_EN
    check("u0 reset cyc_cnt", cc0, 0);
`endif
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

    // ---- u0: sweep length and done/busy timing ----
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    first_done = -1; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
      if (done0) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = i;
          check("u0 busy during done", busy0, 0);
          check("u0 vec_cnt at done", vc0, 16);
          check("u0 sig at done", sig0, 16'h0000);
          check("u0 last vector a", a0, 3);
          check("u0 last vector b", b0, 3);
`ifdef ALU_DRV_CYCLE_CNT_EN
          check("u0 cyc_cnt at done", cc0, 48);
`endif
        end
      end
    end
    check("u0 done edge after start", first_done, 48);
    check("u0 busy cycles", busy_cnt, 48);
    check("u0 done pulses", done_cnt, 1);
    check("u0 vec_cnt holds", vc0, 16);
`ifdef ALU_DRV_CYCLE_CNT_EN
    check("u0 cyc_cnt holds", cc0, 48);
`endif

    // ---- u0: restart clears, then reset in WAIT ----
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    check("u0 restart vec_cnt clear", vc0, 0);
    check("u0 restart busy", busy0, 1);
`ifdef ALU_DRV_CYCLE_CNT_EN
    check("u0 restart cyc_cnt clear", cc0, 0);
`endif
    repeat (4) @(posedge clk);
    #2;
    check("u0 second vector b", b0, 1);
    check("u0 second vector vec_cnt", vc0, 1);
    rst0 = 1'b0;
    #1;
    check("u0 async reset b", b0, 0);
    check("u0 async reset busy", busy0, 0);
    check("u0 async reset vec_cnt", vc0, 0);
    check("u0 async reset done", done0, 0);
`ifdef ALU_DRV_CYCLE_CNT_EN
    check("u0 async reset cyc_cnt", cc0, 0);
`endif
    #1 rst0 = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
    end
    check("u0 no done after reset", done_cnt, 0);
    check("u0 idle after reset", busy_cnt, 0);
    check("u0 vec_cnt after reset", vc0, 0);

    // ---- u1: per-cycle comparison against a time-indexed sweep model ----
    // Period 2 cycles per vector, 32 vectors; vector i is captured at the
    // edge 2*(i+1) cycles after the start edge.
    m_sig = 16'h0000;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 0; c < 68; c++) begin
      @(negedge clk);
      if (c > 0 && (c % 2) == 0 && (c / 2) <= 32) begin
        idx   = c / 2 - 1;
        m_sig = misr(m_sig, resp1(idx / 16, (idx / 4) % 4, idx % 4));
      end
      idx = (c < 64) ? c / 2 : 31;
      if (c < 64 && (c % 2) == 1) cap_log.push_back({sel1, a1, b1, 2'b00});
      check($sformatf("u1 sel c=%0d", c), sel1, idx / 16);
      check($sformatf("u1 a c=%0d", c), a1, (idx / 4) % 4);
      check($sformatf("u1 b c=%0d", c), b1, idx % 4);
      check($sformatf("u1 busy c=%0d", c), busy1, (c < 64) ? 1 : 0);
      check($sformatf("u1 done c=%0d", c), done1, (c == 64) ? 1 : 0);
      check($sformatf("u1 vec_cnt c=%0d", c), vc1, (c < 64) ? c / 2 : 32);
      check($sformatf("u1 sig c=%0d", c), sig1, m_sig);
    end
    check("u1 capture count", cap_log.size(), 32);
    if (cap_log.size() == 32) begin
      check("u1 capture 0", cap_log[0], {4'd0, 2'd0, 2'd0, 2'b00});
      check("u1 capture 1", cap_log[1], {4'd0, 2'd0, 2'd1, 2'b00});
      check("u1 capture 4", cap_log[4], {4'd0, 2'd1, 2'd0, 2'b00});
      check("u1 capture 16", cap_log[16], {4'd1, 2'd0, 2'd0, 2'b00});
      check("u1 capture 31", cap_log[31], {4'd1, 2'd3, 2'd3, 2'b00});
    end

    // ---- u2: signature folds with res_in=1 ----
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("u2 first fold", sig2, 16'h0001);
    check("u2 first vec_cnt", vc2, 1);
    repeat (3) @(posedge clk); #1;
    check("u2 second fold", sig2, 16'h0003);
    repeat (6) @(posedge clk); #1;
    check("u2 done", done2, 1);
    check("u2 final sig", sig2, 16'h000F);
    check("u2 final vec_cnt", vc2, 4);

    // ---- u3: full sweep through the behavioural harness ----
    m_sig = 16'h0000;
    for (int s = 0; s < 10; s++)
      for (int a = 0; a < 32; a++)
        for (int b = 0; b < 32; b++)
          m_sig = misr(m_sig, 16'(alu5(s, 5'(a), 5'(b))));
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    k = 0;
    while (!done3 && k < 40000) begin
      @(posedge clk); #1;
      k++;
    end
    check("u3 done edge after start", k, 30720);
    check("u3 sig vs model", sig3, m_sig);
    check("u3 vec_cnt", vc3, 10240);
    check("u3 busy at done", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
